// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the digit-serial adder.
//   state_t     - controller state encoding (IDLE, RUN, DONE)
//   calc_steps  - number of digit steps per operation (WIDTH / DIGIT)
//   calc_cnt_w  - digit counter width, at least one bit
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int calc_cnt_w(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// serial_adder_digit: combinational DIGIT-bit ripple of one-bit full adders.
// Ports:
//   a, b       - operand digits
//   carry_in   - carry into bit 0 of the digit
//   sum        - sum digit
//   carry_out  - carry out of the top bit of the digit
//   carry_msb  - carry into the top bit of the digit (for signed overflow)
module serial_adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carry_in,
    output logic [DIGIT-1:0] sum,
    output logic             carry_out,
    output logic             carry_msb
);
    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = carry_in;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign carry_out = c[DIGIT];
    assign carry_msb = c[DIGIT - 1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, WIDTH-bit operands added DIGIT bits per
// clock with a registered carry, valid/ready handshakes on both sides.
// Ports:
//   clk, reset            - clock (rising edge), synchronous active-high reset
//   in_valid / in_ready   - operand handshake; in_ready only while idle
//   a, b, carryin         - operands and carry into bit 0
//   sub                   - (SERIAL_ADDER_SUB_EN only) compute a + ~b + carryin
//   out_valid / out_ready - result handshake; result held until accepted
//   sum, carryout         - result bits and carry out of bit WIDTH-1
//   overflow              - signed overflow of the addition
// Build option: define SERIAL_ADDER_SUB_EN to add the sub input.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | adding one digit per clock, low digit first
// DONE  | result held on sum/carryout/overflow, out_valid high
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);
    localparam int K  = calc_steps(WIDTH, DIGIT);
    localparam int CW = calc_cnt_w(K);
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT must divide WIDTH exactly");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sub_q;
    logic             sub_in;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             d_cmsb;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction inverts B digit by digit; carryin supplies the +1.
    assign b_dig = b_sh[DIGIT-1:0] ^ {DIGIT{sub_q}};

    serial_adder_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a        (a_sh[DIGIT-1:0]),
        .b        (b_dig),
        .carry_in (carry),
        .sum      (d_sum),
        .carry_out(d_cout),
        .carry_msb(d_cmsb)
    );

    // Sum digits enter at the MSB end so the first digit lands at bit 0
    // after K shifts.
    if (DIGIT == WIDTH) begin : g_one_step
        logic unused_acc;
        assign acc_next   = d_sum;
        assign unused_acc = ^acc;
    end else begin : g_multi_step
        logic unused_acc_lsb;
        assign acc_next       = {d_sum, acc[WIDTH-1:DIGIT]};
        assign unused_acc_lsb = ^acc[DIGIT-1:0];
    end

    assign in_ready = (state == ST_IDLE) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sub_q     <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= carryin;
                        sub_q <= sub_in;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_next;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum       <= acc_next;
                        carryout  <= d_cout;
                        overflow  <= d_cout ^ d_cmsb;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: two instances (WIDTH=8 with DIGIT=1 and DIGIT=4) checked
// against a transaction-level model every cycle, plus directed vectors with
// hand-computed results.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       in_valid  [2];
    logic       out_ready [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] sum_o     [2];
    logic       co_o      [2];
    logic       ovf_o     [2];

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid[0]),
        .in_ready (in_ready[0]),
        .a        (a),
        .b        (b),
        .carryin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid[0]),
        .out_ready(out_ready[0]),
        .sum      (sum_o[0]),
        .carryout (co_o[0]),
        .overflow (ovf_o[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid[1]),
        .in_ready (in_ready[1]),
        .a        (a),
        .b        (b),
        .carryin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid[1]),
        .out_ready(out_ready[1]),
        .sum      (sum_o[1]),
        .carryout (co_o[1]),
        .overflow (ovf_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {overflow, carryout, sum[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic c, input logic s);
        logic [7:0] yy;
        logic [8:0] t;
        logic       v;
        yy = (SUB_EN && s) ? ~y : y;
        t  = {1'b0, x} + {1'b0, yy} + {8'd0, c};
        v  = (x[7] == yy[7]) && (t[7] != x[7]);
        return {v, t};
    endfunction

    function automatic int steps_of(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    // Transaction-level monitor: one operation in flight per instance.
    int         cyc = 0;
    logic       busy      [2] = '{1'b0, 1'b0};
    int         acc_cyc   [2] = '{0, 0};
    logic [9:0] exp_r     [2] = '{10'd0, 10'd0};
    logic       reset_prev = 1'b1;

    always @(negedge clk) begin
        logic exp_ov;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                chk($sformatf("d%0d_rst_in_ready", d), in_ready[d], 0);
                if (reset_prev)
                    chk($sformatf("d%0d_rst_out_valid", d), out_valid[d], 0);
                busy[d] = 1'b0;
            end else begin
                exp_ov = busy[d] && (cyc >= acc_cyc[d] + steps_of(d) + 1);
                chk($sformatf("d%0d_in_ready", d), in_ready[d], !busy[d]);
                chk($sformatf("d%0d_out_valid", d), out_valid[d], exp_ov);
                if (exp_ov && out_valid[d]) begin
                    chk($sformatf("d%0d_sum", d), sum_o[d], exp_r[d][7:0]);
                    chk($sformatf("d%0d_carryout", d), co_o[d], exp_r[d][8]);
                    chk($sformatf("d%0d_overflow", d), ovf_o[d], exp_r[d][9]);
                end
                if (exp_ov && out_ready[d]) begin
                    busy[d] = 1'b0;
                end else if (!busy[d] && in_valid[d]) begin
                    busy[d]    = 1'b1;
                    acc_cyc[d] = cyc;
                    exp_r[d]   = model(a, b, cin, sub);
                end
            end
        end
        reset_prev = reset;
    end

    // One full operation on instance d; hold = cycles of back-pressure.
    task automatic do_op(input int d, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tcin, input logic tsub, input int hold,
                         output logic [7:0] rs, output logic rco, output logic rov,
                         output int lat);
        int guard;
        a = ta;
        b = tb_v;
        cin = tcin;
        sub = tsub;
        out_ready[d] = (hold == 0);
        in_valid[d] = 1'b1;
        guard = 0;
        while (!in_ready[d] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        rs  = sum_o[d];
        rco = co_o[d];
        rov = ovf_o[d];
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       c;
    } vec_t;

    vec_t vecs [5] = '{
        '{8'h7F, 8'h01, 1'b0},
        '{8'h00, 8'h00, 1'b1},
        '{8'hAA, 8'h55, 1'b1},
        '{8'hFF, 8'hFF, 1'b1},
        '{8'h3C, 8'hC3, 1'b0}
    };

    initial begin
        logic [7:0] rs;
        logic       rco;
        logic       rov;
        logic [9:0] m;
        int         lat;

        reset = 1'b1;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sum", sum_o[0], 0);
        chk("reset_carryout", co_o[0], 0);
        chk("reset_overflow", ovf_o[0], 0);
        chk("reset_out_valid", out_valid[0], 0);
        chk("reset_in_ready", in_ready[0], 0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready[0], 1);

        do_op(0, 8'h5A, 8'h33, 1'b0, 1'b0, 0, rs, rco, rov, lat);
        chk("v5a33_sum", rs, 8'h8D);
        chk("v5a33_carryout", rco, 0);
        chk("v5a33_overflow", rov, 1);
        chk("v5a33_latency", lat, 8);

        do_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, rs, rco, rov, lat);
        chk("vff01_sum", rs, 8'h00);
        chk("vff01_carryout", rco, 1);
        chk("vff01_overflow", rov, 0);

        do_op(1, 8'h80, 8'h80, 1'b1, 1'b0, 0, rs, rco, rov, lat);
        chk("d4_v8080_sum", rs, 8'h01);
        chk("d4_v8080_carryout", rco, 1);
        chk("d4_v8080_overflow", rov, 1);
        chk("d4_v8080_latency", lat, 2);

        // Back-pressure with in_valid held high the whole time.
        a = 8'h12;
        b = 8'h34;
        cin = 1'b0;
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        a = 8'h77;
        b = 8'h11;
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 8);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_sum", sum_o[0], 8'h46);
            chk("bp_carryout", co_o[0], 0);
            chk("bp_in_ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after_hs", in_ready[0], 1);
        chk("bp_valid_after_hs", out_valid[0], 0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_next_sum", sum_o[0], 8'h88);
        chk("bp_next_overflow", ovf_o[0], 1);
        @(posedge clk); #1;

        // Reset during RUN abandons the operation.
        a = 8'hF0;
        b = 8'h0F;
        cin = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready[0], 0);
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_sum", sum_o[0], 0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready_after", in_ready[0], 1);
        repeat (12) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", out_valid[0], 0);
        end
        do_op(0, 8'h01, 8'h01, 1'b0, 1'b0, 0, rs, rco, rov, lat);
        chk("after_rst_sum", rs, 8'h02);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                do_op(d, vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, i % 3, rs, rco, rov, lat);
                m = model(vecs[i].x, vecs[i].y, vecs[i].c, 1'b0);
                chk($sformatf("tbl_d%0d_%0d", d, i), {rov, rco, rs}, m);
            end
        end

`ifdef SERIAL_ADDER_SUB_EN
        for (int d = 0; d < 2; d++) begin
            do_op(d, 8'h05, 8'h07, 1'b1, 1'b1, 0, rs, rco, rov, lat);
            chk($sformatf("sub_d%0d_sum", d), rs, 8'hFE);
            chk($sformatf("sub_d%0d_carryout", d), rco, 0);
            chk($sformatf("sub_d%0d_overflow", d), rov, 0);
        end
        sub = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands DIGIT bits per clock, using a chain of one-bit full adders plus a registered carry. It is the sequential, handshaked successor to the single-bit full adder. It serves area-constrained datapaths that trade latency for a narrow adder slice. Operands enter through a valid/ready input handshake, and the result leaves through a valid/ready output handshake.

## Interface
- WIDTH, 32, operand and result width in bits
- DIGIT, 1, bits added per clock; must divide WIDTH exactly, otherwise elaboration error
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand presented
- in_ready  output  1  block idle and able to accept
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carryin  input  1  carry into bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result bits
- carryout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- K = WIDTH/DIGIT digit steps per operation.
- States:
  - IDLE: in_ready=1.
  - RUN: processes one digit per cycle.
  - DONE: out_valid=1, result held.
- IDLE→RUN on in_valid && in_ready. Captures a, b, and carryin (and sub when the feature is compiled in) into shift registers and the carry register. The digit counter clears.
- RUN: each edge adds the low DIGIT bits of the A and B shift registers with the carry register. Both registers shift right by DIGIT. The sum digit enters the result register at its MSB end, and the carry register updates. Overflow is computed from the MSB slice on the final step.
- RUN→DONE on the edge that completes digit K-1.
- DONE→IDLE on out_valid && out_ready.
- in_valid is ignored outside IDLE, and the input buses are don't-care after capture.
- sum, carryout and overflow are stable throughout DONE. They keep their last values in IDLE and RUN.
- Reset values: state IDLE, in_ready=0 while reset is high, out_valid=0, sum=0, carryout=0, overflow=0, and all internal registers 0.
- Reset mid-operation abandons the operation, so out_valid never asserts for it.

## Timing
- An operand accepted on edge E0 produces out_valid=1 after edge E_K, which is K cycles of latency. With K=1, out_valid asserts one cycle after acceptance.
- No bypass between handshakes:
  - in_ready returns 1 in the cycle after the output handshake edge.
  - Peak throughput is one result per K+2 cycles.
- in_ready is 1 in the first cycle after reset deasserts.
- Back-pressure: out_valid and the result hold indefinitely while out_ready=0.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds port sub (input, 1 bit), captured with the operands.
  - When sub=1, the block computes a + ~b + carryin, so carryin=1 yields a−b.
  - carryout=1 means no borrow.
- Undefined: no sub port, and the block computes a + b + carryin only.

## Structure
- Package serial_adder_pkg holds:
  - the state encoding (IDLE, RUN, DONE)
  - the K and counter-width ($clog2(K), minimum 1) derivation helpers
- Sub-module serial_adder_digit: combinational DIGIT-bit ripple of one-bit full adders. Outputs are the sum digit, carry out, and the carry into the top bit (used for overflow).

## Test plan
- WIDTH=8, DIGIT=1, a=8'h5A, b=8'h33, carryin=0 → sum=8'h8D, carryout=0, overflow=1, out_valid exactly 8 cycles after the accept edge.
- WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, carryin=0 → sum=8'h00, carryout=1, overflow=0.
- WIDTH=8, DIGIT=4, a=8'h80, b=8'h80, carryin=1 → sum=8'h01, carryout=1, overflow=1, out_valid 2 cycles after accept.
- out_ready held 0 for 5 cycles in DONE → out_valid, sum and carryout unchanged and in_ready=0. After the handshake, in_ready=1 on the next cycle and in_valid held high throughout is not accepted early.
- Reset asserted on RUN cycle 3 → out_valid stays 0, in_ready=0 during reset and 1 after. A new op a=8'h01, b=8'h01, carryin=0 → sum=8'h02.
- With SERIAL_ADDER_SUB_EN, sub=1, a=8'h05, b=8'h07, carryin=1 → sum=8'hFE, carryout=0, overflow=0.
